// File: rtl/muldiv_unit_pkg.sv
// Shared ALU definitions plus the multiply/divide sequencer state type.
//   alu_operation_t : operation select used across the ALU and muldiv_unit
//   flag_t          : single-bit status/sign flag
//   muldiv_state_t  : IDLE / CALC / FINISH sequencer states
package muldiv_unit_pkg;

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLL    = 5'd2,
    SLT    = 5'd3,
    SLTU   = 5'd4,
    SRL    = 5'd5,
    SRA    = 5'd6,
    MUL    = 5'd7,
    MULH   = 5'd8,
    MULHSU = 5'd9,
    MULHU  = 5'd10,
    DIV    = 5'd11,
    DIVU   = 5'd12,
    REM    = 5'd13,
    REMU   = 5'd14
  } alu_operation_t;

  typedef logic flag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  // True for the eight operations handled by muldiv_unit.
  function automatic logic is_muldiv_op(input alu_operation_t op);
    case (op)
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // True for the divide/remainder family.
  function automatic logic is_div_op(input alu_operation_t op);
    case (op)
      DIV, DIVU, REM, REMU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. One bit per cycle: radix-2 shift-add for the multiply
// family, restoring shift-subtract for the divide family, both on operand magnitudes with a
// combinational sign fix-up at the end.
// Ports:
//   clk, rstN      : clock, asynchronous active-low reset
//   start, opSel   : request and operation (only the eight muldiv ops are accepted)
//   bus_a, bus_b   : signed operands A and B
//   flush          : abort the operation in flight; also blocks acceptance in IDLE
//   busy           : high in CALC and FINISH
//   done           : one-cycle pulse while out carries a fresh result
//   out            : result, held until the next completed operation
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         start,
  input  alu_operation_t               opSel,
  input  logic signed [DATA_WIDTH-1:0] bus_a,
  input  logic signed [DATA_WIDTH-1:0] bus_b,
  input  logic                         flush,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] out
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH);
  localparam logic [W-1:0]    MinVal  = {1'b1, {(W-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  alu_operation_t  op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;     // {hi, lo} product, or {remainder, quotient}
  logic [W-1:0]    opnd_q, opnd_d;   // multiplicand or divisor magnitude
  flag_t           neg_q, neg_d;     // product / quotient is negative
  flag_t           rem_neg_q, rem_neg_d;
  logic [W-1:0]    res_q, res_d;     // result presented during FINISH
  logic [W-1:0]    out_q, out_d;     // last committed result

  // ---------------------------------------------------------------------------------------
  // Operand decode at accept time
  // ---------------------------------------------------------------------------------------
  logic [W-1:0] a_u, b_u, a_mag, b_mag, bypass_res;
  flag_t        a_sgn, b_sgn, a_neg, b_neg;
  logic         div_zero, div_ovf, bypass;

  assign a_u = $unsigned(bus_a);
  assign b_u = $unsigned(bus_b);

  // MUL is treated as unsigned: the low half is identical either way.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (opSel)
      MULH, DIV, REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      MULHSU:  a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_sgn & a_u[W-1];
  assign b_neg = b_sgn & b_u[W-1];
  assign a_mag = a_neg ? (~a_u + 1'b1) : a_u;
  assign b_mag = b_neg ? (~b_u + 1'b1) : b_u;

  assign div_zero = (b_u == '0);
  assign div_ovf  = ((opSel == DIV) || (opSel == REM)) && (a_u == MinVal) && (b_u == '1);
  assign bypass   = is_div_op(opSel) && (div_zero || div_ovf);

  always_comb begin
    if (div_zero) begin
      bypass_res = ((opSel == DIV) || (opSel == DIVU)) ? '1 : a_u;
    end else begin
      bypass_res = (opSel == DIV) ? MinVal : '0;
    end
  end

  // ---------------------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_rsh;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  // Add the multiplicand into the high half when the current multiplier bit is set, then
  // shift the whole accumulator right; the carry becomes the new top bit.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Shift {rem, quo} left one bit and try subtracting the divisor. The partial remainder
  // is always below the divisor, so a successful subtraction fits in W bits.
  assign div_rsh  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge   = (div_rsh >= {1'b0, opnd_q});
  assign div_diff = div_rsh[W-1:0] - opnd_q;
  assign div_next = {(div_ge ? div_diff : div_rsh[W-1:0]), acc_q[W-2:0], div_ge};

  // ---------------------------------------------------------------------------------------
  // Sign fix-up and result selection
  // ---------------------------------------------------------------------------------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, final_res;

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
  assign rem_fix  = rem_neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

  always_comb begin
    final_res = '0;
    case (op_q)
      MUL:                  final_res = prod_fix[W-1:0];
      MULH, MULHSU, MULHU:  final_res = prod_fix[2*W-1:W];
      DIV, DIVU:            final_res = quo_fix;
      REM, REMU:            final_res = rem_fix;
      default:              final_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    res_d     = res_q;
    out_d     = out_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush && is_muldiv_op(opSel)) begin
          op_d      = opSel;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          if (bypass) begin
            res_d   = bypass_res;
            acc_d   = '0;
            opnd_d  = '0;
            state_d = FINISH;
          end else if (is_div_op(opSel)) begin
            acc_d   = {{W{1'b0}}, a_mag};
            opnd_d  = b_mag;
            state_d = CALC;
          end else begin
            acc_d   = {{W{1'b0}}, b_mag};
            opnd_d  = a_mag;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == LastCnt) begin
          res_d   = final_res;
          state_d = FINISH;
        end else begin
          acc_d = is_div_op(op_q) ? div_next : mul_next;
          cnt_d = cnt_q + CntW'(1);
        end
      end

      FINISH: begin
        // start is ignored here; a held start is taken next cycle from IDLE.
        state_d = IDLE;
        if (!flush) begin
          out_d = res_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      op_q      <= ADD;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      res_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      res_q     <= res_d;
      out_q     <= out_d;
    end
  end

  // A flush during FINISH suppresses the pulse and keeps the previous result visible.
  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH) && !flush;
  assign out  = done ? res_q : out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, aborts, and randomized
// operations against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MinV = 32'h8000_0000;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                start = 1'b0;
  logic                flush = 1'b0;
  alu_operation_t      opSel = ADD;
  logic signed [W-1:0] bus_a = '0;
  logic signed [W-1:0] bus_b = '0;
  logic                busy;
  logic                done;
  logic signed [W-1:0] out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_out = '0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .opSel (opSel),
    .bus_a (bus_a),
    .bus_b (bus_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_operation_t op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   r;
    int             lat;
  } vec_t;

  // Reference: plain 64-bit arithmetic with the special cases written out.
  function automatic logic [W-1:0] ref_model(input alu_operation_t op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    p  = '0;
    case (op)
      MUL, MULH: p = sa * sb;
      MULHSU:    p = sa * ub;
      MULHU:     p = {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == '0) return '1;
        if (a == MinV && b == '1) return MinV;
        p = sa / sb;
      end
      REM: begin
        if (b == '0) return a;
        if (a == MinV && b == '1) return '0;
        p = sa % sb;
      end
      DIVU: begin
        if (b == '0) return '1;
        p = {32'h0, a / b};
      end
      REMU: begin
        if (b == '0) return a;
        p = {32'h0, a % b};
      end
      default: p = '0;
    endcase
    if (op == MULH || op == MULHSU || op == MULHU) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_latency(input alu_operation_t op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (is_div_op(op) && b == '0) return 1;
    if ((op == DIV || op == REM) && a == MinV && b == '1) return 1;
    return 34;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, wait for done (bounded), then step one more cycle.
  // lat counts edges from the accept edge (which is edge 1) to the edge that raises done.
  task automatic run_op(input alu_operation_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit interfere,
                        output logic [W-1:0] res, output int lat,
                        output bit busy_ok, output bit pulse_ok);
    start = 1'b1;
    opSel = op;
    bus_a = a;
    bus_b = b;
    tick();
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (interfere && lat >= 3 && lat < 8) begin
        start = 1'b1;
        opSel = MULHU;
        bus_a = $urandom;
        bus_b = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    res = out;
    tick();
    pulse_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b out=%h expected 0 0 00000000",
               busy, done, out);
    end
    tick();
    tick();
    rstN = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b out=%h expected 0 00000000", busy, out);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[11];
    logic [W-1:0] res;
    int lat;
    bit bok, pok;
    vecs[0]  = '{MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 34};
    vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[2]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34};
    vecs[7]  = '{DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{REMU,   32'd5,         32'd0,         32'h0000_0005, 1};
    vecs[9]  = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat, bok, pok);
      checks++;
      if (res !== vecs[i].r) begin
        errors++;
        $display("FAIL directed_%0d_%s result: got %h expected %h", i, vecs[i].op.name(),
                 res, vecs[i].r);
      end
      checks++;
      if (lat !== vecs[i].lat) begin
        errors++;
        $display("FAIL directed_%0d_%s latency: got %0d expected %0d", i, vecs[i].op.name(),
                 lat, vecs[i].lat);
      end
      checks++;
      if (bok !== 1'b1 || pok !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d_%s busy/pulse: got busy_ok=%b pulse_ok=%b expected 1 1",
                 i, vecs[i].op.name(), bok, pok);
      end
      exp_out = vecs[i].r;
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL directed_%0d_hold: got %h expected %h", i, out, exp_out);
      end
    end
  endtask

  task automatic test_idle_rejects();
    bit bad;
    bad = 1'b0;
    start = 1'b1;
    opSel = SLT;
    bus_a = 32'd3;
    bus_b = 32'd4;
    tick();
    if (busy !== 1'b0) bad = 1'b1;
    opSel = MUL;
    flush = 1'b1;
    tick();
    if (busy !== 1'b0) bad = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    tick();
    if (done !== 1'b0) bad = 1'b1;
    checks++;
    if (bad !== 1'b0 || out !== exp_out) begin
      errors++;
      $display("FAIL idle_rejects: got bad=%b out=%h expected 0 %h", bad, out, exp_out);
    end
  endtask

  task automatic test_flush();
    bit saw_done;
    saw_done = 1'b0;
    start = 1'b1;
    opSel = MUL;
    bus_a = 32'd12345;
    bus_b = 32'd678;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out !== exp_out) begin
      errors++;
      $display("FAIL flush_calc: got busy=%b out=%h expected 0 %h", busy, out, exp_out);
    end
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_done: got done seen=%b expected 0", saw_done);
    end
    // Flush in the FINISH cycle itself.
    start = 1'b1;
    opSel = MULHU;
    bus_a = 32'd99;
    bus_b = 32'd77;
    tick();
    start = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || out !== exp_out) begin
      errors++;
      $display("FAIL flush_finish: got busy=%b done=%b out=%h expected 1 0 %h",
               busy, done, out, exp_out);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out !== exp_out) begin
      errors++;
      $display("FAIL flush_finish_after: got busy=%b out=%h expected 0 %h", busy, out, exp_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res, a, b;
    int lat;
    bit bok, pok;
    start = 1'b1;
    opSel = DIVU;
    bus_a = $urandom;
    bus_b = 32'd13;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b out=%h expected 0 0 00000000",
               busy, done, out);
    end
    exp_out = '0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    a = $urandom;
    b = $urandom;
    run_op(MULHU, a, b, 1'b0, res, lat, bok, pok);
    checks++;
    if (res !== ref_model(MULHU, a, b) || lat !== 34 || pok !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: got %h lat %0d expected %h lat 34", res, lat,
               ref_model(MULHU, a, b));
    end
    exp_out = ref_model(MULHU, a, b);
  endtask

  task automatic test_start_busy();
    logic [W-1:0] res, a, b;
    int lat;
    bit bok, pok;
    a = $urandom;
    b = $urandom_range(1, 1000);
    run_op(DIV, a, b, 1'b1, res, lat, bok, pok);
    checks++;
    if (res !== ref_model(DIV, a, b) || lat !== 34) begin
      errors++;
      $display("FAIL start_busy_result: got %h lat %0d expected %h lat 34", res, lat,
               ref_model(DIV, a, b));
    end
    exp_out = ref_model(DIV, a, b);
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || pok !== 1'b1 || bok !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_queued: got busy=%b pulse_ok=%b expected 0 1", busy, pok);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, res;
    int lat;
    a1 = $urandom;
    b1 = $urandom;
    a2 = $urandom;
    b2 = $urandom_range(1, 50000);
    start = 1'b1;
    opSel = MULH;
    bus_a = a1;
    bus_b = b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (out !== ref_model(MULH, a1, b1) || lat !== 34) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d expected %h lat 34", out, lat,
               ref_model(MULH, a1, b1));
    end
    exp_out = ref_model(MULH, a1, b1);
    // Present the next request during the done cycle and keep it held.
    start = 1'b1;
    opSel = REM;
    bus_a = a2;
    bus_b = b2;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle_start: got busy=%b expected 0", busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_next: got busy=%b expected 1", busy);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    res = out;
    checks++;
    if (res !== ref_model(REM, a2, b2) || lat !== 34) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected %h lat 34", res, lat,
               ref_model(REM, a2, b2));
    end
    exp_out = ref_model(REM, a2, b2);
    tick();
  endtask

  task automatic test_random();
    alu_operation_t ops[8];
    alu_operation_t op;
    logic [W-1:0] a, b, res, exp_r;
    int lat, exp_l;
    bit bok, pok;
    ops = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    for (int i = 0; i < 32; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = MinV; b = '1; end
        2: b = $urandom_range(1, 9);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      exp_r = ref_model(op, a, b);
      exp_l = ref_latency(op, a, b);
      run_op(op, a, b, 1'b0, res, lat, bok, pok);
      checks++;
      if (res !== exp_r || lat !== exp_l || bok !== 1'b1 || pok !== 1'b1) begin
        errors++;
        $display("FAIL random_%0d_%s a=%h b=%h: got %h lat %0d expected %h lat %0d",
                 i, op.name(), a, b, res, lat, exp_r, exp_l);
      end
      exp_out = exp_r;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_rejects();
    test_flush();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: requests an operation when high.
REQ-005 SHALL have port opSel, input, alu_operation_t: the operation. Only MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU are valid here.
REQ-006 SHALL have ports bus_a and bus_b, input, signed DATA_WIDTH each: operand A and operand B.
REQ-007 SHALL have port flush, input, 1 bit: abort the current operation (pipeline kill).
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when out is valid.
REQ-010 SHALL have port out, output, signed DATA_WIDTH: the result.

Function
REQ-011 SHALL use a state machine with states IDLE, CALC and FINISH.
REQ-012 Accept rule: SHALL accept a request only in IDLE, with start=1, flush=0 and a valid opSel.
REQ-013 Invalid opSel: a start with any other opSel SHALL be ignored and the block SHALL stay in IDLE.
REQ-014 Start while busy: start in CALC or FINISH SHALL be ignored, with no queueing.
REQ-015 Capture on accept: SHALL latch opSel and operand magnitudes, and latch the result sign for the signedness of the op:
- MULH, DIV, REM: both operands signed.
- MULHSU: A signed, B unsigned.
- MUL: either signedness, since the low bits are identical.
- Unsigned ops: no sign.
REQ-016 Normal path: the accept edge SHALL move the block to CALC.
REQ-017 CALC SHALL perform exactly DATA_WIDTH iterations:
- Multiply: radix-2 shift-add on magnitudes into a 2*DATA_WIDTH accumulator.
- Divide: restoring shift-subtract producing quotient and remainder.
REQ-018 After the last iteration SHALL enter FINISH, apply the sign fix-up and register out. done SHALL be high for exactly the one FINISH cycle, then the block returns to IDLE.
REQ-019 Normal latency: done SHALL be high in the cycle after the (DATA_WIDTH+1)th rising edge following the accept edge, i.e. 34 edges for DATA_WIDTH=32.
REQ-020 Result selection:
- MUL: low half of the product.
- MULH, MULHSU, MULHU: high half of the 2*DATA_WIDTH product.
- DIV/DIVU: quotient.
- REM/REMU: remainder.
REQ-021 Sign rules: the quotient SHALL truncate toward zero. The remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero SHALL bypass CALC and go directly to FINISH (done one edge after accept):
- DIV and DIVU: out = all ones.
- REM and REMU: out = bus_a.
REQ-023 Signed overflow (DIV or REM with bus_a = most-negative and bus_b = -1) SHALL bypass CALC: DIV out = most-negative, REM out = 0, done one edge after accept.
REQ-024 busy SHALL be high in CALC and FINISH, and low in IDLE.
REQ-025 out SHALL hold its last value until the next FINISH.
REQ-026 flush=1 in CALC or FINISH SHALL return the block to IDLE on the next edge with no done pulse, and out unchanged. flush in IDLE SHALL block acceptance.
REQ-027 Simultaneous events: done and a new start in the same cycle SHALL NOT accept that start; it is accepted the following cycle in IDLE.

Reset
REQ-028 rstN=0 SHALL immediately force state to IDLE, busy=0, done=0 and out=0, and clear the iteration counter and accumulators, regardless of the clock.
REQ-029 Reset mid-operation SHALL discard the operation with no done pulse. The first accept after rstN deasserts SHALL behave as from power-up.

Structure
REQ-030 alu_operation_t and flag_t SHALL be reused from the shared definitions package. A new muldiv_state_t enum (IDLE, CALC, FINISH) SHALL be added to that package.
REQ-031 The iteration counter SHALL be $clog2(DATA_WIDTH)+1 bits and derived from DATA_WIDTH, with no hard-coded 32.
REQ-032 SHALL be a single module with no sub-module; the sign fix-up SHALL be combinational logic inside it.

Verification
REQ-033 Bench SHALL cover MUL bus_a=-3, bus_b=7 -> out=0xFFFFFFEB, done exactly 34 edges after accept, busy high throughout.
REQ-034 Bench SHALL cover bus_a=0xFFFFFFFF, bus_b=0xFFFFFFFF for three ops:
- MULHU -> 0xFFFFFFFE.
- MULH -> 0x00000000.
- MULHSU -> 0xFFFFFFFF.
REQ-035 Bench SHALL cover DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, and DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-036 Bench SHALL cover DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done one edge after accept.
REQ-037 Bench SHALL cover DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, each with done one edge after accept.
REQ-038 Bench SHALL cover abort cases:
- flush at iteration 10 -> no done, IDLE next edge, out unchanged.
- rstN low at iteration 20 -> busy=0 and out=0 immediately.
- start during CALC -> ignored.
